// File: rtl/mult_pkg.sv
// Shared constants, state type and operand helpers used by the multiply sequencer
// and by the shift-add multiplier that sits beside it.
package mult_pkg;

    // Operand helpers below are sized by WORD_W, so the sequencer's WIDTH must equal it.
    localparam int WORD_W = 32;

    localparam logic [5:0] MULT_IDLE = 6'd0;
    localparam logic [5:0] MULT_INIT = 6'd1;
    localparam logic [5:0] MULT_WORK = 6'd2;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_INIT = 2'd1,
        S_WORK = 2'd2
    } seq_state_t;

    // -0x80000000 wraps to 0x80000000, which is the correct unsigned magnitude.
    function automatic logic [WORD_W-1:0] abs_w(input logic [WORD_W-1:0] value,
                                                input logic              signed_en);
        return (signed_en && value[WORD_W-1]) ? -value : value;
    endfunction

    function automatic logic [2*WORD_W-1:0] neg_2w(input logic [2*WORD_W-1:0] value);
        return -value;
    endfunction

endpackage

// File: rtl/mult_hilo_ctrl.sv
// MULT/MULTU sequencer: prepares magnitudes for the shift-add multiplier, waits for it,
// sign-corrects the product and owns the HI/LO registers (including MTHI/MTLO writes).
module mult_hilo_ctrl
    import mult_pkg::*;
#(
    parameter int WIDTH = WORD_W
) (
    input  logic               Clk,
    input  logic               reset,
    input  logic               start,
    input  logic               is_signed,
    input  logic [WIDTH-1:0]   rs,
    input  logic [WIDTH-1:0]   rt,
    input  logic               hi_we,
    input  logic               lo_we,
    input  logic [WIDTH-1:0]   wdata,
    input  logic               mult_end,
    input  logic [5:0]         mult_counter,
    input  logic [2*WIDTH-1:0] mult_result,
    output logic [5:0]         mult_state,
    output logic [WIDTH-1:0]   mult_lhs,
    output logic [WIDTH-1:0]   mult_rhs,
    output logic [WIDTH-1:0]   hi,
    output logic [WIDTH-1:0]   lo,
    output logic               busy,
    output logic               done,
    output seq_state_t         fsm_state
);

    // Request handshake: start is a one-cycle request that is accepted only when busy=0
    // (state S_IDLE); busy rises on the following cycle and stays high until the cycle in
    // which done pulses for exactly one cycle. Requests made while busy are dropped.
    localparam logic [5:0] COUNT_DONE = 6'(WIDTH);

    seq_state_t         state;
    logic               neg;
    logic [WIDTH-1:0]   lhs_mag;
    logic [WIDTH-1:0]   rhs_mag;
    logic               start_neg;
    logic               complete;
    logic [2*WIDTH-1:0] product;

    always_comb begin
        lhs_mag   = abs_w(rs, is_signed);
        rhs_mag   = abs_w(rt, is_signed);
        start_neg = is_signed & (rs[WIDTH-1] ^ rt[WIDTH-1]);
        // The end flag is stale-high while idle; only the counter proves a fresh finish.
        complete  = mult_end && (mult_counter == COUNT_DONE);
        product   = neg ? neg_2w(mult_result) : mult_result;
    end

    always_ff @(posedge Clk or negedge reset) begin
        if (!reset) begin
            state      <= S_IDLE;
            mult_state <= MULT_IDLE;
            mult_lhs   <= '0;
            mult_rhs   <= '0;
            neg        <= 1'b0;
            hi         <= '0;
            lo         <= '0;
            busy       <= 1'b0;
            done       <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (hi_we) hi <= wdata;
                    if (lo_we) lo <= wdata;
                    if (start) begin
                        mult_lhs   <= lhs_mag;
                        mult_rhs   <= rhs_mag;
                        neg        <= start_neg;
                        state      <= S_INIT;
                        mult_state <= MULT_INIT;
                        busy       <= 1'b1;
                    end
                end
                S_INIT: begin
                    state      <= S_WORK;
                    mult_state <= MULT_WORK;
                end
                S_WORK: begin
                    if (complete) begin
                        {hi, lo}   <= product;
                        done       <= 1'b1;
                        busy       <= 1'b0;
                        state      <= S_IDLE;
                        mult_state <= MULT_IDLE;
                    end
                end
                default: begin
                    state      <= S_IDLE;
                    mult_state <= MULT_IDLE;
                    busy       <= 1'b0;
                end
            endcase
        end
    end

    assign fsm_state = state;

endmodule

// File: doc/mult_hilo_ctrl.md
Name: mult_hilo_ctrl

Overview:
Sequencer and result stage in front of the iterative shift-add multiplier.
- Accepts MULT/MULTU requests from the main control unit.
- Prepares unsigned magnitudes and drives the multiplier's state code and operands.
- Waits for completion, applies the sign correction, and holds the architectural HI/LO registers, including the MTHI/MTLO writes.

Parameters:
- WIDTH, 32, operand width; HI/LO are each WIDTH bits and the product is 2*WIDTH bits.

Ports:
- Clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-low reset.
- start  input  1  request a multiply; sampled only in IDLE.
- is_signed  input  1  1 = MULT (two's complement), 0 = MULTU.
- rs, rt  input  WIDTH  source operands.
- hi_we, lo_we  input  1  MTHI/MTLO write strobes.
- wdata  input  WIDTH  data for MTHI/MTLO.
- mult_end  input  1  multiplier end flag.
- mult_counter  input  6  multiplier iteration counter.
- mult_result  input  2*WIDTH  multiplier unsigned product.
- mult_state  output  6  state code to multiplier: 0 idle, 1 init, 2 work.
- mult_lhs, mult_rhs  output  WIDTH  unsigned operand magnitudes.
- hi, lo  output  WIDTH  architectural HI/LO.
- busy  output  1  high from the cycle after start is accepted until done.
- done  output  1  one-cycle pulse when HI/LO are updated by a multiply.

Behaviour:
- Reset (reset=0, asynchronous): FSM=S_IDLE, mult_state=0, mult_lhs=mult_rhs=0, hi=lo=0, busy=0, done=0, neg flag=0.
- FSM states: S_IDLE, S_INIT, S_WORK.
- S_IDLE:
  - mult_state=0, busy=0.
  - On start=1, register:
    - mult_lhs = (is_signed & rs[WIDTH-1]) ? -rs : rs
    - mult_rhs = (is_signed & rt[WIDTH-1]) ? -rt : rt
    - neg = is_signed & (rs[WIDTH-1] ^ rt[WIDTH-1])
  - Then go to S_INIT.
- S_INIT:
  - mult_state=1 for exactly one cycle, busy=1.
  - Go to S_WORK unconditionally.
- S_WORK:
  - mult_state=2, busy=1.
  - mult_end alone is never trusted, because it is stale-high from idle.
  - Completion requires mult_end=1 AND mult_counter==WIDTH, sampled at the same edge.
  - On completion: {hi,lo} = neg ? -mult_result : mult_result (2*WIDTH-bit two's complement); done=1 for the following cycle; go to S_IDLE.
- Latency: the edge sampling start is edge 0. S_INIT is active for edge 1, and the work iterations run on edges 2..33. The multiplier raises its end flag at edge 34. Completion is sampled at edge 35; done and new HI/LO are visible after edge 35.
- Negation wrap: -(0x80000000) = 0x80000000 is the correct unsigned magnitude and must not be special-cased.
- start while busy: ignored; no queuing.
- hi_we/lo_we:
  - In S_IDLE, write wdata at the next edge; both strobes may be active in the same cycle.
  - While busy, they are ignored.
  - start and hi_we in the same IDLE cycle: the write occurs, and the later multiply result overwrites it.
- done never coincides with busy=1. busy deasserts in the same cycle done asserts.
- Reset mid-operation: immediate return to reset values. The multiplier is reset from the same source at top level.
- No combinational path from any input to any output; all outputs are registered.

Decomposition:
- Shared package mult_pkg:
  - MULT_IDLE/MULT_INIT/MULT_WORK 6-bit constants, shared with the multiplier.
  - seq_state_t enum {S_IDLE, S_INIT, S_WORK}.
  - Functions abs_w(value, signed_en) and neg_2w(value).
- No sub-module required; the multiplier is instantiated beside this block at the top level, not inside it.

Test Plan:
- Unsigned basic: MULTU rs=3, rt=5 -> done 35 cycles after start edge; hi=0x00000000, lo=0x0000000F; busy high for the intervening cycles.
- Signed mixed: MULT rs=0xFFFFFFFE (-2), rt=3 -> mult_lhs=2, mult_rhs=3; hi=0xFFFFFFFF, lo=0xFFFFFFFA.
- Extremes:
  - MULTU 0xFFFFFFFF*0xFFFFFFFF -> hi=0xFFFFFFFE, lo=0x00000001.
  - MULT 0x80000000*0x80000000 -> hi=0x40000000, lo=0x00000000.
- Stale end flag: hold mult_end=1 from idle with counter=0 through S_WORK start -> no early done; done only once counter==32 and end=1.
- Busy protection: second start and hi_we with wdata=0xDEADBEEF mid-operation -> both ignored; result of the first op only; then in IDLE, hi_we=lo_we=1, wdata=0x12345678 -> hi=lo=0x12345678 next cycle.
- Reset mid-op: drop reset at cycle 10 of a multiply -> hi=lo=0, busy=0, done=0, mult_state=0 immediately; a fresh multiply afterwards completes normally.
